// File: rtl/trig_axis_sequencer.sv
// Time-shares one sin/cos datapath over the x, y and z rotation angles.
// Each angle is reduced into [0, 2pi) before it is issued to the datapath.
module trig_axis_sequencer #(
  parameter int              AW       = 12,
  parameter int              RW       = 14,
  parameter logic [AW-1:0]   TWO_PI   = 12'h648,
  parameter int              TRIG_LAT = 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [AW-1:0] angle_x,
  input  logic [AW-1:0] angle_y,
  input  logic [AW-1:0] angle_z,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_angle,
  output logic          trig_valid,
  input  logic [RW-1:0] trig_sin,
  input  logic [RW-1:0] trig_cos,
  output logic [RW-1:0] sin_x,
  output logic [RW-1:0] cos_x,
  output logic [RW-1:0] sin_y,
  output logic [RW-1:0] cos_y,
  output logic [RW-1:0] sin_z,
  output logic [RW-1:0] cos_z,
  output logic [1:0]    dbg_state
);

  // Handshake: a request is taken on an edge where start && ready; start at
  // any other time is dropped, and angle_* are sampled only on that edge.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(TRIG_LAT);

  state_t        state;
  logic [AW-1:0] work_x, work_y, work_z;
  logic [AW-1:0] cur;
  logic [1:0]    axis;
  logic [3:0]    cnt;

  assign dbg_state = state;

  always_comb begin
    cur = work_z;
    case (axis)
      2'd0:    cur = work_x;
      2'd1:    cur = work_y;
      default: cur = work_z;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_valid <= 1'b0;
      trig_angle <= '0;
      work_x     <= '0;
      work_y     <= '0;
      work_z     <= '0;
      axis       <= 2'd0;
      cnt        <= 4'd0;
      sin_x      <= '0;
      cos_x      <= '0;
      sin_y      <= '0;
      cos_y      <= '0;
      sin_z      <= '0;
      cos_z      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work_x <= angle_x;
            work_y <= angle_y;
            work_z <= angle_z;
            axis   <= 2'd0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          // One subtraction per cycle; at most two are ever needed for AW=12.
          if (cur >= TWO_PI) begin
            case (axis)
              2'd0:    work_x <= cur - TWO_PI;
              2'd1:    work_y <= cur - TWO_PI;
              default: work_z <= cur - TWO_PI;
            endcase
          end else begin
            trig_angle <= cur;
            cnt        <= LAT;
            trig_valid <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            case (axis)
              2'd0: begin
                sin_x <= trig_sin;
                cos_x <= trig_cos;
              end
              2'd1: begin
                sin_y <= trig_sin;
                cos_y <= trig_cos;
              end
              default: begin
                sin_z <= trig_sin;
                cos_z <= trig_cos;
              end
            endcase
            trig_valid <= 1'b0;
            if (axis == 2'd2) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              axis  <= axis + 2'd1;
              state <= S_REDUCE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          ready      <= 1'b1;
          trig_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_axis_sequencer.sv
// Bench for trig_axis_sequencer: table vectors, random requests against a
// mod/div reference model, reset and handshake corner cases, TRIG_LAT=3 copy.
module tb_trig_axis_sequencer;

  localparam int            AW     = 12;
  localparam int            RW     = 14;
  localparam logic [AW-1:0] TWO_PI = 12'h648;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- DUT, TRIG_LAT = 1 ----------------
  logic          start;
  logic [AW-1:0] angle_x, angle_y, angle_z;
  logic          ready, busy, done, trig_valid;
  logic [AW-1:0] trig_angle;
  logic [RW-1:0] trig_sin, trig_cos;
  logic [RW-1:0] sin_x, cos_x, sin_y, cos_y, sin_z, cos_z;
  logic [1:0]    dbg_state;

  trig_axis_sequencer #(.TRIG_LAT(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z),
    .ready(ready), .busy(busy), .done(done),
    .trig_angle(trig_angle), .trig_valid(trig_valid),
    .trig_sin(trig_sin), .trig_cos(trig_cos),
    .sin_x(sin_x), .cos_x(cos_x), .sin_y(sin_y), .cos_y(cos_y),
    .sin_z(sin_z), .cos_z(cos_z), .dbg_state(dbg_state)
  );

  // ---------------- DUT, TRIG_LAT = 3 ----------------
  logic          start3;
  logic [AW-1:0] angle_x3, angle_y3, angle_z3;
  logic          ready3, busy3, done3, trig_valid3;
  logic [AW-1:0] trig_angle3;
  logic [RW-1:0] trig_sin3, trig_cos3;
  logic [RW-1:0] sin_x3, cos_x3, sin_y3, cos_y3, sin_z3, cos_z3;
  logic [1:0]    dbg_state3;

  trig_axis_sequencer #(.TRIG_LAT(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start3),
    .angle_x(angle_x3), .angle_y(angle_y3), .angle_z(angle_z3),
    .ready(ready3), .busy(busy3), .done(done3),
    .trig_angle(trig_angle3), .trig_valid(trig_valid3),
    .trig_sin(trig_sin3), .trig_cos(trig_cos3),
    .sin_x(sin_x3), .cos_x(cos_x3), .sin_y(sin_y3), .cos_y(cos_y3),
    .sin_z(sin_z3), .cos_z(cos_z3), .dbg_state(dbg_state3)
  );

  // ---------------- datapath model (Q4.8 in, Q2.12 out) ----------------
  function automatic logic [RW-1:0] q212(input real x);
    real s;
    int  v;
    s = x * 4096.0;
    v = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    return v[RW-1:0];
  endfunction

  function automatic logic [RW-1:0] sin_q(input logic [AW-1:0] a);
    return q212($sin(real'(a) / 256.0));
  endfunction

  function automatic logic [RW-1:0] cos_q(input logic [AW-1:0] a);
    return q212($cos(real'(a) / 256.0));
  endfunction

  always_comb begin
    trig_sin = sin_q(trig_angle);
    trig_cos = cos_q(trig_angle);
  end

  // Second datapath drives junk for the first two cycles of every WAIT run.
  int wait_cyc3;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         wait_cyc3 <= 0;
    else if (!trig_valid3) wait_cyc3 <= 0;
    else                  wait_cyc3 <= wait_cyc3 + 1;
  end

  always_comb begin
    trig_sin3 = 14'h1555;
    trig_cos3 = 14'h2AAA;
    if (trig_valid3 && wait_cyc3 >= 2) begin
      trig_sin3 = sin_q(trig_angle3);
      trig_cos3 = cos_q(trig_angle3);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] model_red(input logic [AW-1:0] a);
    return AW'(int'(a) % int'(TWO_PI));
  endfunction

  function automatic int model_n(input logic [AW-1:0] a, b, c, input int lat);
    return (1 + int'(a) / int'(TWO_PI) + lat) +
           (1 + int'(b) / int'(TWO_PI) + lat) +
           (1 + int'(c) / int'(TWO_PI) + lat);
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [AW-1:0] ang_q[$];
  logic [RW-1:0] last_res[6];
  bit            have_last;
  int            n_checks;
  int            n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input logic [AW-1:0] a0, a1, a2);
    ang_q.push_back(a0);
    ang_q.push_back(a1);
    ang_q.push_back(a2);
    exp_q.push_back(sin_q(a0)); exp_q.push_back(cos_q(a0));
    exp_q.push_back(sin_q(a1)); exp_q.push_back(cos_q(a1));
    exp_q.push_back(sin_q(a2)); exp_q.push_back(cos_q(a2));
  endtask

  function automatic logic [RW-1:0] get_res(input int i);
    case (i)
      0:       return sin_x;
      1:       return cos_x;
      2:       return sin_y;
      3:       return cos_y;
      4:       return sin_z;
      default: return cos_z;
    endcase
  endfunction

  function automatic logic [RW-1:0] get_res3(input int i);
    case (i)
      0:       return sin_x3;
      1:       return cos_x3;
      2:       return sin_y3;
      3:       return cos_y3;
      4:       return sin_z3;
      default: return cos_z3;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // pre_raise: caller is in the DONE cycle of the previous request; start is
  // raised there, must be ignored, and is taken on the following IDLE edge.
  task automatic run_req(input logic [AW-1:0] ax, ay, az, input int exp_n,
                         input bit disturb, input bit pre_raise);
    logic [AW-1:0] seen[$];
    logic [AW-1:0] ea;
    logic [RW-1:0] er;
    logic [AW-1:0] act_a;
    int  n;
    bit  got_done;
    logic prev_tv;
    if (pre_raise) begin
      start = 1'b1; angle_x = ax; angle_y = ay; angle_z = az;
    end
    @(posedge Clk); #1;
    check("idle_ready", ready, 1);
    check("idle_done", done, 0);
    check("idle_trig_valid", trig_valid, 0);
    if (!pre_raise) begin
      @(negedge Clk);
      start = 1'b1; angle_x = ax; angle_y = ay; angle_z = az;
    end
    @(posedge Clk); #1;
    start = 1'b0;
    if (disturb) begin
      angle_x = ~ax; angle_y = ~ay; angle_z = ~az;
    end
    if (have_last)
      for (int i = 0; i < 6; i++) check("hold_results", get_res(i), last_res[i]);
    n = 0; got_done = 0; prev_tv = 1'b0;
    while (!got_done && n < 200) begin
      @(posedge Clk); #1;
      n++;
      if (disturb && (n == 1 || n == 3)) start = 1'b1;
      if (disturb && (n == 2 || n == 4)) start = 1'b0;
      if (trig_valid && !prev_tv) seen.push_back(trig_angle);
      prev_tv = trig_valid;
      check("ready_low_busy", ready, 0);
      if (done) begin
        got_done = 1;
        check("busy_in_done", busy, 1);
      end
    end
    start = 1'b0;
    check("done_edge", n, exp_n);
    check("angle_count", seen.size(), 3);
    for (int i = 0; i < 3; i++) begin
      ea = ang_q.pop_front();
      act_a = (i < seen.size()) ? seen[i] : ~ea;
      check("trig_angle_seq", act_a, ea);
    end
    for (int i = 0; i < 6; i++) begin
      er = exp_q.pop_front();
      check("result", get_res(i), er);
      last_res[i] = er;
    end
    have_last = 1;
  endtask

  task automatic run3(input logic [AW-1:0] ax, ay, az);
    int n;
    logic [RW-1:0] er;
    push_expect(model_red(ax), model_red(ay), model_red(az));
    void'(ang_q.pop_front()); void'(ang_q.pop_front()); void'(ang_q.pop_front());
    @(negedge Clk);
    start3 = 1'b1; angle_x3 = ax; angle_y3 = ay; angle_z3 = az;
    @(posedge Clk); #1;
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    check("lat3_done_edge", n, model_n(ax, ay, az, 3));
    for (int i = 0; i < 6; i++) begin
      er = exp_q.pop_front();
      check("lat3_result", get_res3(i), er);
    end
    @(posedge Clk); #1;
    check("lat3_done_width", done3, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] ax, ay, az;
    bit            disturb, pre_raise;
    logic [AW-1:0] e0, e1, e2;
    int            exp_n;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] rx, ry, rz;
    bit            pr;
    bit            saw_done;
    n_checks = 0; n_fail = 0; have_last = 0;
    start = 0; angle_x = '0; angle_y = '0; angle_z = '0;
    start3 = 0; angle_x3 = '0; angle_y3 = '0; angle_z3 = '0;

    vecs[0] = '{12'h000, 12'h192, 12'h324, 1'b0, 1'b0, 12'h000, 12'h192, 12'h324, 6};
    vecs[1] = '{12'hFFF, 12'h648, 12'h647, 1'b0, 1'b0, 12'h36F, 12'h000, 12'h647, 9};
    vecs[2] = '{12'h080, 12'h400, 12'h600, 1'b1, 1'b0, 12'h080, 12'h400, 12'h600, 6};
    vecs[3] = '{12'h192, 12'h192, 12'h192, 1'b0, 1'b0, 12'h192, 12'h192, 12'h192, 6};
    vecs[4] = '{12'h192, 12'h192, 12'h192, 1'b0, 1'b1, 12'h192, 12'h192, 12'h192, 6};

    repeat (3) @(posedge Clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig_valid", trig_valid, 0);
    check("rst_trig_angle", trig_angle, 0);
    check("rst_sin_x", sin_x, 0);
    check("rst_cos_z", cos_z, 0);
    check("rst_state", dbg_state, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) last_res[i] = '0;
    have_last = 1;

    for (int i = 0; i < 5; i++) begin
      push_expect(vecs[i].e0, vecs[i].e1, vecs[i].e2);
      run_req(vecs[i].ax, vecs[i].ay, vecs[i].az, vecs[i].exp_n,
              vecs[i].disturb, vecs[i].pre_raise);
      if (i == 0) begin
        check("plan_sin_x", sin_x, 14'h0000);
        check("plan_cos_x", cos_x, 14'h1000);
        check("plan_sin_y", sin_y, 14'h1000);
        check("plan_cos_z", cos_z, 14'h3000);
      end
    end

    for (int k = 0; k < 10; k++) begin
      rx = AW'($urandom_range(0, 4095));
      ry = AW'($urandom_range(0, 4095));
      rz = AW'($urandom_range(0, 4095));
      pr = 1'($urandom_range(0, 1));
      push_expect(model_red(rx), model_red(ry), model_red(rz));
      run_req(rx, ry, rz, model_n(rx, ry, rz, 1), 1'($urandom_range(0, 1)), pr);
    end

    // Asynchronous reset while axis y is waiting on the datapath.
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b1; angle_x = 12'h100; angle_y = 12'h200; angle_z = 12'h300;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("pre_rst_trig_valid", trig_valid, 1);
    check("pre_rst_trig_angle", trig_angle, 12'h200);
    check("pre_rst_sin_x", sin_x, sin_q(12'h100));
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_ready", ready, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_trig_valid", trig_valid, 0);
    check("arst_trig_angle", trig_angle, 0);
    check("arst_sin_x", sin_x, 0);
    check("arst_state", dbg_state, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    saw_done = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (done) saw_done = 1;
    end
    check("arst_no_done", saw_done, 0);
    for (int i = 0; i < 6; i++) last_res[i] = '0;
    push_expect(12'h100, 12'h200, 12'h300);
    run_req(12'h100, 12'h200, 12'h300, 6, 1'b0, 1'b0);

    // Longer datapath latency with junk on the first two WAIT cycles.
    run3(12'h100, 12'h200, 12'h300);
    run3(12'hFFF, 12'h648, 12'h000);
    for (int k = 0; k < 3; k++)
      run3(AW'($urandom_range(0, 4095)), AW'($urandom_range(0, 4095)),
           AW'($urandom_range(0, 4095)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
